div: RTL

//  Multi-cycle radix-2 restoring divider serving the EX stage for DIV/DIVU.
//  EX issues operands with start_i and holds them, stalling the pipeline

---
 rtl/div.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// One quotient bit is resolved per clock; results are {remainder, quotient}.
//
// Handshake: EX raises start_i with stable operands and keeps it high until
// it sees ready_o. ready_o and result_o are registered and stay valid for as
// long as start_i remains high. Dropping start_i releases the divider, which
// returns to FREE on the following edge. A new request is accepted only from
// FREE, so start_i must be low for at least one cycle between divides.
module div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic [1:0]         dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   dividend_q;   // {partial remainder, dividend/quotient bits}
  logic [WIDTH-1:0]     divisor_q;
  logic                 neg_quo_q;
  logic                 neg_rem_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;

  logic [WIDTH-1:0]     op1_abs_d;
  logic [WIDTH-1:0]     op2_abs_d;
  logic [WIDTH:0]       minuend_d;
  logic [WIDTH:0]       trial_d;
  logic [2*WIDTH-1:0]   dividend_d;
  logic [WIDTH-1:0]     quo_fix_d;
  logic [WIDTH-1:0]     rem_fix_d;

  // Operand magnitudes: negative signed operands become their two's-complement magnitude.
  always_comb begin
    op1_abs_d = opdata1_i;
    op2_abs_d = opdata2_i;
    if (signed_div_i && opdata1_i[WIDTH-1]) op1_abs_d = -opdata1_i;
    if (signed_div_i && opdata2_i[WIDTH-1]) op2_abs_d = -opdata2_i;
  end

  // One restoring step: bit WIDTH of the WIDTH+1-bit trial is the borrow.
  always_comb begin
    minuend_d  = dividend_q[2*WIDTH-1:WIDTH-1];
    trial_d    = minuend_d - {1'b0, divisor_q};
    dividend_d = {dividend_q[2*WIDTH-2:0], 1'b0};
    if (!trial_d[WIDTH]) begin
      dividend_d = {trial_d[WIDTH-1:0], dividend_q[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    quo_fix_d = dividend_q[WIDTH-1:0];
    rem_fix_d = dividend_q[2*WIDTH-1:WIDTH];
    if (neg_quo_q) quo_fix_d = -dividend_q[WIDTH-1:0];
    if (neg_rem_q) rem_fix_d = -dividend_q[2*WIDTH-1:WIDTH];
  end

  // Divider control FSM with registered result/ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (start_i && !annul_i) begin
            divisor_q  <= op2_abs_d;
            neg_quo_q  <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_q  <= signed_div_i && opdata1_i[WIDTH-1];
            dividend_q <= {{WIDTH{1'b0}}, op1_abs_d};
            cnt_q      <= '0;
            if (opdata2_i == '0) begin
              state_q <= S_BY_ZERO;
            end else begin
              state_q <= S_ON;
            end
          end
        end
        S_BY_ZERO: begin
          if (annul_i) begin
            state_q <= S_FREE;
          end else begin
            result_q <= '0;
            ready_q  <= 1'b1;
            state_q  <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state_q <= S_FREE;
            ready_q <= 1'b0;
          end else if (cnt_q == CNT_W'(WIDTH)) begin
            result_q <= {rem_fix_d, quo_fix_d};
            ready_q  <= 1'b1;
            state_q  <= S_END;
          end else begin
            dividend_q <= dividend_d;
            cnt_q      <= cnt_q + 1'b1;
          end
        end
        S_END: begin
          if (!start_i) begin
            state_q  <= S_FREE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
        default: state_q <= S_FREE;
      endcase
    end
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign dbg_state_o = state_q;

endmodule
